// File: rtl/apb2ahb_bridge.sv
`default_nettype none
// ============================================================================
// Module   : apb2ahb_bridge
// Purpose  : APB completer that turns each APB transfer into a single AHB-Lite
//            SINGLE NONSEQ transfer into a fixed address window.
// Revision : 1.0 - initial release
// ============================================================================
module apb2ahb_bridge #(
    parameter int                    PADDR_WIDTH = 16,
    parameter int                    HADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter logic [HADDR_WIDTH-1:0] HADDR_BASE = 32'h4000_0000
) (
    input  logic                    hclk,
    input  logic                    hresetn,
    // APB completer side
    input  logic                    psel,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [PADDR_WIDTH-1:0]  paddr,
    input  logic [DATA_WIDTH-1:0]   pwdata,
    input  logic [DATA_WIDTH/8-1:0] pstrb,
    output logic                    pready,
    output logic [DATA_WIDTH-1:0]   prdata,
    output logic                    pslverr,
    // AHB-Lite master side
    output logic [HADDR_WIDTH-1:0]  haddr,
    output logic [1:0]              htrans,
    output logic                    hwrite,
    output logic [2:0]              hsize,
    output logic [2:0]              hburst,
    output logic [DATA_WIDTH-1:0]   hwdata,
    output logic [DATA_WIDTH/8-1:0] hwstrb,
    input  logic                    hready,
    input  logic                    hresp,
    input  logic [DATA_WIDTH-1:0]   hrdata
);

    localparam int                     ALIGN_BITS = $clog2(DATA_WIDTH / 8);
    localparam logic [PADDR_WIDTH-1:0] ALIGN_MASK = PADDR_WIDTH'((1 << ALIGN_BITS) - 1);
    localparam logic [2:0]             HSIZE_VAL  = 3'(ALIGN_BITS);
    localparam logic [1:0]             HTRANS_IDLE   = 2'b00;
    localparam logic [1:0]             HTRANS_NONSEQ = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    state_t state;
    logic   err;     // AHB ERROR seen during the current data phase
    logic   abort;   // APB requester dropped psel before completion

    // Every transfer is a full-width single beat.
    assign hsize  = HSIZE_VAL;
    assign hburst = 3'b000;

    // Bridge FSM: capture APB setup, run one AHB transfer, answer on APB.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state   <= ST_IDLE;
            err     <= 1'b0;
            abort   <= 1'b0;
            pready  <= 1'b0;
            pslverr <= 1'b0;
            prdata  <= '0;
            haddr   <= '0;
            htrans  <= HTRANS_IDLE;
            hwrite  <= 1'b0;
            hwdata  <= '0;
            hwstrb  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (psel && !penable) begin
                        // APB inputs are only looked at here; the AHB side
                        // then works from these registered copies.
                        haddr  <= {HADDR_BASE[HADDR_WIDTH-1:PADDR_WIDTH], paddr & ~ALIGN_MASK};
                        hwrite <= pwrite;
                        hwdata <= pwdata;
                        hwstrb <= pwrite ? pstrb : '0;
                        htrans <= HTRANS_NONSEQ;
                        err    <= 1'b0;
                        abort  <= 1'b0;
                        state  <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (!psel) begin
                        abort <= 1'b1;
                    end
                    if (hready) begin
                        htrans <= HTRANS_IDLE;
                        state  <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (!psel) begin
                        abort <= 1'b1;
                    end
                    if (hready) begin
                        if (!hwrite) begin
                            prdata <= hrdata;
                        end
                        // An abandoned APB transfer still finishes on AHB
                        // (it cannot be cancelled) but is never answered.
                        pready  <= psel && !abort;
                        pslverr <= psel && !abort && (err || hresp);
                        err     <= err || hresp;
                        state   <= ST_RESP;
                    end else if (hresp) begin
                        // First cycle of the two-cycle ERROR response.
                        err <= 1'b1;
                    end
                end
                ST_RESP: begin
                    pready  <= 1'b0;
                    pslverr <= 1'b0;
                    err     <= 1'b0;
                    abort   <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_apb2ahb_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb2ahb_bridge
// Purpose  : Scoreboard bench for apb2ahb_bridge: APB driver, behavioural AHB
//            slave, and an APB response monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb2ahb_bridge;

    logic        hclk;
    logic        hresetn;
    logic        psel, penable, pwrite;
    logic [15:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic        pready, pslverr;
    logic [31:0] prdata;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize, hburst;
    logic [31:0] hwdata;
    logic [3:0]  hwstrb;
    logic        hready, hresp;
    logic [31:0] hrdata;

    apb2ahb_bridge dut (
        .hclk(hclk), .hresetn(hresetn),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .pstrb(pstrb), .pready(pready), .prdata(prdata),
        .pslverr(pslverr), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
        .hsize(hsize), .hburst(hburst), .hwdata(hwdata), .hwstrb(hwstrb),
        .hready(hready), .hresp(hresp), .hrdata(hrdata)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    // What the slave should see for one transfer and how it will answer.
    typedef struct {
        logic        wr;
        logic [31:0] haddr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          aw;
        int          dw;
        logic        err;
        logic [31:0] rdata;
    } scfg_t;

    // What the APB requester should get back.
    typedef struct {
        int          cyc;
        logic        err;
        logic [31:0] prdata;
    } resp_t;

    scfg_t slave_q[$];
    resp_t resp_q[$];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int pready_count = 0;
    logic [31:0] last_rd = 32'h0;

    always @(posedge hclk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural AHB slave ----------------
    int    sphase = 0;   // 0 idle, 1 address phase, 2 data phase
    int    acnt, dcnt;
    scfg_t cur;

    always @(negedge hclk) begin
        if (!hresetn) begin
            sphase = 0;
            hready = 1'b1;
            hresp  = 1'b0;
        end else begin
            if (sphase == 0 && htrans == 2'b10) begin
                if (slave_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_nonseq: got htrans=%0b with no transfer issued, required 0", htrans);
                end else begin
                    cur    = slave_q.pop_front();
                    sphase = 1;
                    acnt   = 0;
                end
            end else if (sphase == 0) begin
                chk("htrans_idle", htrans, 2'b00);
                hready = 1'b1;
                hresp  = 1'b0;
            end
            if (sphase == 1) begin
                chk("addr_htrans", htrans, 2'b10);
                chk("addr_haddr", haddr, cur.haddr);
                chk("addr_hwrite", hwrite, cur.wr);
                chk("addr_hwstrb", hwstrb, cur.strb);
                chk("addr_hsize", hsize, 3'd2);
                chk("addr_hburst", hburst, 3'd0);
                hresp = 1'b0;
                if (acnt == cur.aw) begin
                    hready = 1'b1;
                    sphase = 2;
                    dcnt   = 0;
                end else begin
                    hready = 1'b0;
                    acnt++;
                end
            end else if (sphase == 2) begin
                chk("data_htrans", htrans, 2'b00);
                chk("data_haddr", haddr, cur.haddr);
                chk("data_hwrite", hwrite, cur.wr);
                chk("data_hwstrb", hwstrb, cur.strb);
                if (cur.wr) chk("data_hwdata", hwdata, cur.wdata);
                hready = (dcnt == cur.dw);
                hresp  = cur.err && (dcnt + 1 >= cur.dw);
                hrdata = hready ? cur.rdata : $urandom;
                if (hready) sphase = 0;
                else        dcnt++;
            end
        end
    end

    // ---------------- APB response monitor ----------------
    resp_t mon_r;
    always @(negedge hclk) begin
        if (hresetn && pready) begin
            pready_count++;
            if (resp_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_pready: got pready=1 at cycle %0d, required no pulse", cyc);
            end else begin
                mon_r = resp_q.pop_front();
                chk("pready_cycle", cyc, mon_r.cyc);
                chk("pslverr", pslverr, mon_r.err);
                chk("prdata", prdata, mon_r.prdata);
            end
        end
    end

    // ---------------- APB driver with reference model ----------------
    task automatic apb_xfer(input logic wr, input logic [15:0] addr, input logic [31:0] wd,
                            input logic [3:0] st, input int aw, input int dw, input logic er,
                            input logic [31:0] rd, input bit abort_it);
        scfg_t c;
        resp_t r;
        int    n;
        int    base;
        @(negedge hclk);
        c.wr    = wr;
        c.haddr = 32'h4000_0000 + {16'h0, addr - (addr % 16'd4)};
        c.wdata = wd;
        c.strb  = wr ? st : 4'h0;
        c.aw    = aw;
        c.dw    = dw;
        c.err   = er;
        c.rdata = rd;
        slave_q.push_back(c);
        if (!abort_it) begin
            r.cyc    = cyc + 3 + aw + dw;
            r.err    = er;
            r.prdata = wr ? last_rd : rd;
            resp_q.push_back(r);
        end
        if (!wr) last_rd = rd;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd; pstrb = st;
        @(negedge hclk);
        // Captured values must be used from here on, so scramble the bus.
        penable = 1'b1; paddr = 16'($urandom); pwdata = $urandom; pstrb = 4'($urandom);
        if (abort_it) begin
            @(negedge hclk);
            psel = 1'b0; penable = 1'b0;
            base = pready_count;
            repeat (aw + dw + 5) @(negedge hclk);
            chk("abort_no_pready", pready_count, base);
        end else begin
            n = 0;
            while (!pready && n < 60) begin
                @(negedge hclk);
                n++;
            end
            if (!pready) begin
                tests++; fails++;
                $display("FAIL pready_timeout: got no pready after %0d cycles, required a pulse", n);
            end
            psel = 1'b0; penable = 1'b0;
        end
    endtask

    task automatic check_reset_values();
        chk("rst_pready", pready, 1'b0);
        chk("rst_pslverr", pslverr, 1'b0);
        chk("rst_prdata", prdata, 32'h0);
        chk("rst_haddr", haddr, 32'h0);
        chk("rst_htrans", htrans, 2'b00);
        chk("rst_hwrite", hwrite, 1'b0);
        chk("rst_hsize", hsize, 3'd2);
        chk("rst_hburst", hburst, 3'd0);
        chk("rst_hwdata", hwdata, 32'h0);
        chk("rst_hwstrb", hwstrb, 4'h0);
    endtask

    initial begin
        logic        wr, er;
        logic [15:0] a;
        logic [31:0] wd, rd;
        logic [3:0]  st;
        int          aw, dw;

        hresetn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0;
        hready = 1'b1; hresp = 1'b0; hrdata = '0;
        repeat (3) @(negedge hclk);
        check_reset_values();
        hresetn = 1'b1;

        // Directed cases
        apb_xfer(1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, 0, 0, 1'b0, 32'h0, 1'b0);
        apb_xfer(1'b0, 16'h0104, 32'h0, 4'hF, 0, 2, 1'b0, 32'h1234_5678, 1'b0);
        apb_xfer(1'b1, 16'h0200, 32'hA5A5_0001, 4'h3, 0, 1, 1'b1, 32'h0, 1'b0);
        apb_xfer(1'b1, 16'h0204, 32'hA5A5_0002, 4'hC, 0, 0, 1'b0, 32'h0, 1'b0);
        apb_xfer(1'b1, 16'h0000, 32'h0BAD_F00D, 4'hF, 0, 0, 1'b0, 32'h0, 1'b0);
        apb_xfer(1'b0, 16'h0004, 32'h0, 4'h0, 0, 0, 1'b0, 32'hCAFE_0004, 1'b0);
        apb_xfer(1'b1, 16'h0013, 32'h1357_9BDF, 4'h1, 1, 0, 1'b0, 32'h0, 1'b0);
        apb_xfer(1'b1, 16'h0080, 32'h7777_7777, 4'hF, 0, 1, 1'b0, 32'h0, 1'b1);
        apb_xfer(1'b0, 16'h0084, 32'h0, 4'h0, 0, 0, 1'b0, 32'h8888_0084, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            wr = 1'($urandom); a = 16'($urandom); wd = $urandom; st = 4'($urandom);
            aw = $urandom_range(0, 2); dw = $urandom_range(0, 3);
            er = ($urandom % 4 == 0);
            if (er && dw == 0) dw = 1;
            rd = $urandom;
            repeat ($urandom_range(0, 2)) @(negedge hclk);
            apb_xfer(wr, a, wd, st, aw, dw, er, rd, 1'b0);
        end

        // Reset in the middle of a data phase
        @(negedge hclk);
        begin
            scfg_t c;
            c.wr = 1'b1; c.haddr = 32'h4000_0040; c.wdata = 32'h5555_AAAA; c.strb = 4'hF;
            c.aw = 0; c.dw = 6; c.err = 1'b0; c.rdata = 32'h0;
            slave_q.push_back(c);
        end
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h0040; pwdata = 32'h5555_AAAA; pstrb = 4'hF;
        @(negedge hclk);
        penable = 1'b1;
        @(negedge hclk);
        #1;
        hresetn = 1'b0;
        slave_q.delete();
        resp_q.delete();
        psel = 1'b0; penable = 1'b0;
        #1;
        check_reset_values();
        @(negedge hclk);
        #1;
        hresetn = 1'b1;
        last_rd = 32'h0;
        apb_xfer(1'b0, 16'h0300, 32'h0, 4'h0, 0, 1, 1'b0, 32'h2468_ACE0, 1'b0);
        apb_xfer(1'b1, 16'h0304, 32'h1111_2222, 4'hF, 0, 0, 1'b0, 32'h0, 1'b0);

        repeat (5) @(negedge hclk);
        chk("slave_queue_drained", slave_q.size(), 0);
        chk("resp_queue_drained", resp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000 time units, required $finish earlier");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/apb2ahb_bridge.md
Name: apb2ahb_bridge

Overview:
- APB completer to AHB-Lite single-master bridge; the reverse direction of the AHB-to-APB path.
- Lets an APB-side agent (debug/config port) reach AHB address space; each APB transfer becomes exactly one AHB SINGLE NONSEQ transfer.
- Single clock domain: APB and AHB both run on hclk.
- Sits between an APB requester and the AHB interconnect as a master port.

Parameters:
- PADDR_WIDTH, 16, APB address width.
- HADDR_WIDTH, 32, AHB address width (must be > PADDR_WIDTH).
- DATA_WIDTH, 32, data width for both buses: 8, 16 or 32.
- HADDR_BASE, 32'h4000_0000, window base; haddr upper bits come from HADDR_BASE[HADDR_WIDTH-1:PADDR_WIDTH].

Ports:
- hclk  in  1  clock for both sides.
- hresetn  in  1  reset, asynchronous, active-low.
- psel  in  1  APB select.
- penable  in  1  APB enable.
- pwrite  in  1  APB direction.
- paddr  in  PADDR_WIDTH  APB address.
- pwdata  in  DATA_WIDTH  APB write data.
- pstrb  in  DATA_WIDTH/8  APB write strobes.
- pready  out  1  APB ready.
- prdata  out  DATA_WIDTH  APB read data.
- pslverr  out  1  APB error.
- haddr  out  HADDR_WIDTH  AHB address.
- htrans  out  2  AHB transfer type.
- hwrite  out  1  AHB direction.
- hsize  out  3  AHB size.
- hburst  out  3  AHB burst type.
- hwdata  out  DATA_WIDTH  AHB write data.
- hwstrb  out  DATA_WIDTH/8  AHB write strobes.
- hready  in  1  AHB ready.
- hresp  in  1  AHB response (1 = ERROR).
- hrdata  in  DATA_WIDTH  AHB read data.

Behaviour:
- Reset values: all outputs 0; htrans=IDLE(2'b00); hburst=SINGLE(3'b000); hsize=log2(DATA_WIDTH/8); FSM in IDLE. Reset mid-transfer aborts immediately with no completion to APB.
- FSM states: IDLE, ADDR, DATA, RESP.
- IDLE:
  - On psel=1 and penable=0 (APB setup), capture paddr, pwrite, pwdata, pstrb; go to ADDR.
  - Otherwise stay in IDLE.
- ADDR:
  - htrans=NONSEQ(2'b10).
  - haddr = {HADDR_BASE upper bits, captured paddr} with the low log2(DATA_WIDTH/8) bits forced to 0.
  - hwrite = captured pwrite.
  - Hold until hready=1, then go to DATA. Outside ADDR, htrans=IDLE.
- DATA:
  - hwdata = captured pwdata; hwstrb = captured pstrb on writes, 0 on reads.
  - On hready=1: capture hrdata into prdata (reads only; writes leave prdata unchanged) and capture hresp into an error flag; go to RESP.
  - If hresp=1 while hready=0 (first cycle of the 2-cycle ERROR), set the error flag; stay in DATA.
- RESP:
  - pready=1 and pslverr=error flag for exactly one cycle; then clear the flag and go to IDLE.
  - pready is 0 in every other state.
- Latency: with zero AHB wait states, setup at cycle T gives ADDR at T+1, DATA at T+2, pready at T+3. Each AHB wait state adds one cycle.
- Back-to-back: a new setup phase (psel=1, penable=0) presented the cycle after pready is accepted in IDLE with no bubble beyond the latency above.
- psel deasserted mid-transfer (APB violation): AHB transfer still runs to completion, because AHB cannot be aborted. RESP then does not assert pready or pslverr; return to IDLE.
- haddr, hwrite, hwdata and hwstrb stay stable from ADDR through DATA. The APB inputs are ignored after capture.
- prdata holds its last read value until the next completed read.
- pslverr is qualified only by pready.

Test Plan:
- Zero-wait write: paddr=16'h0010, pwdata=32'hDEADBEEF, pstrb=4'hF.
  -> htrans=NONSEQ, haddr=32'h4000_0010, hwrite=1 at T+1; hwdata=32'hDEADBEEF, hwstrb=4'hF at T+2; pready=1, pslverr=0 at T+3.
- Read with 2 wait states: paddr=16'h0104; hready low for 2 DATA cycles; hrdata=32'h1234_5678.
  -> pready at T+5; prdata=32'h1234_5678; hwstrb=0 throughout.
- AHB error: write to 16'h0200; slave returns hresp=1/hready=0, then hresp=1/hready=1.
  -> pready=1 and pslverr=1 for one cycle; next transfer completes with pslverr=0.
- Back-to-back: write 16'h0000 then read 16'h0004, setup immediately after the first pready.
  -> two NONSEQ transfers with haddr 32'h4000_0000 then 32'h4000_0004; two single-cycle pready pulses, each 3 cycles after its setup.
- Unaligned and abort cases:
  - paddr=16'h0013 -> haddr=32'h4000_0010.
  - psel dropped during DATA -> AHB transfer completes, no pready pulse, FSM returns to IDLE.
- Reset mid-DATA: hresetn low for 1 cycle -> all outputs at reset values, htrans=IDLE; a following transfer completes normally.
